// File: rtl/axi_lite_master_bridge.sv
// Native single-outstanding bus to AXI4-Lite master bridge.
// One transaction in flight; all AXI outputs come from registers or the state decode.
module axi_lite_master_bridge #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            bus_req_valid,
  output logic                            bus_req_ready,
  input  logic [31:0]                     bus_req_addr,
  input  logic                            bus_req_wen,
  input  logic [3:0]                      bus_req_wmask,
  input  logic [31:0]                     bus_req_data,
  output logic                            bus_resp_valid,
  output logic [31:0]                     bus_resp_data,
  output logic                            bus_resp_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]                      M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                    state_q, state_d;
  logic                          aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d, req_addr;
  logic [31:0]                   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]                    wstrb_q, wstrb_d;
  logic                          err_q, err_d;

  // Only the error bit of each response code matters (SLVERR/DECERR).
  logic unused_resp;
  assign unused_resp = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

  if (C_M_AXI_ADDR_WIDTH > 32) begin : g_addr_ext
    assign req_addr = {{(C_M_AXI_ADDR_WIDTH-32){1'b0}}, bus_req_addr};
  end else begin : g_addr_trunc
    assign req_addr = bus_req_addr[C_M_AXI_ADDR_WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: if (bus_req_valid) begin
        addr_d    = req_addr;
        wdata_d   = bus_req_data;
        wstrb_d   = bus_req_wmask;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = bus_req_wen ? S_WR_REQ : S_RD_REQ;
      end
      S_WR_REQ: begin
        // AW and W retire independently; leave once both have handshaken.
        aw_done_d = aw_done_q | M_AXI_AWREADY;
        w_done_d  = w_done_q  | M_AXI_WREADY;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: if (M_AXI_BVALID) begin
        err_d   = M_AXI_BRESP[1];
        rdata_d = 32'h0;
        state_d = S_DONE;
      end
      S_RD_REQ: if (M_AXI_ARREADY) state_d = S_RD_RESP;
      S_RD_RESP: if (M_AXI_RVALID) begin
        err_d   = M_AXI_RRESP[1];
        rdata_d = M_AXI_RDATA[31:0];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus_req_ready  = (state_q == S_IDLE);
  assign bus_resp_valid = (state_q == S_DONE);
  assign bus_resp_data  = rdata_q;
  assign bus_resp_err   = err_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == S_RD_REQ);
  assign M_AXI_RREADY  = (state_q == S_RD_RESP);

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge; the AXI slave is driven step by step.
module tb_axi_lite_master_bridge;

  logic        clk, reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_wmask;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int vecs = 0;
  int errs = 0;

  axi_lite_master_bridge dut (
    .clk(clk), .reset(reset),
    .bus_req_valid(req_valid), .bus_req_ready(req_ready), .bus_req_addr(req_addr),
    .bus_req_wen(req_wen), .bus_req_wmask(req_wmask), .bus_req_data(req_data),
    .bus_resp_valid(resp_valid), .bus_resp_data(resp_data), .bus_resp_err(resp_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; afterwards we sit 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_wen = 0; req_addr = 0; req_data = 0; req_wmask = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, resp_valid}, 0);
    chk("rst_resp", {resp_err, resp_data}, 0);
    chk("rst_prot", {awprot, arprot}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Zero-wait write: accept edge 0, response pulse in cycle 3
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    req_valid = 1; req_wen = 1; req_addr = 32'h1000_0004; req_data = 32'hDEADBEEF; req_wmask = 4'hF;
    chk("w0_ready", req_ready, 1);
    step(); req_valid = 0;
    chk("w0_c1_vld", {awvalid, wvalid, req_ready}, 3'b110);
    chk("w0_awaddr", awaddr, 32'h1000_0004);
    chk("w0_wdata", wdata, 32'hDEADBEEF);
    chk("w0_wstrb", wstrb, 4'hF);
    step();
    chk("w0_c2", {awvalid, wvalid, bready, resp_valid}, 4'b0010);
    step(); bvalid = 0;
    chk("w0_c3_resp", {resp_valid, resp_err}, 2'b10);
    chk("w0_c3_data", resp_data, 0);
    step();
    chk("w0_c4_idle", {resp_valid, req_ready}, 2'b01);

    // Read with ARREADY low for cycles 1-2, RVALID in cycle 7
    awready = 0; wready = 0; arready = 0; rdata = 32'h1234_5678; rresp = 0;
    req_valid = 1; req_wen = 0; req_addr = 32'h2000_0008;
    step(); req_valid = 0;
    chk("r1_c1_ar", arvalid, 1);
    chk("r1_araddr", araddr, 32'h2000_0008);
    step();
    chk("r1_c2_ar", {arvalid, araddr}, {1'b1, 32'h2000_0008});
    step(); arready = 1;
    chk("r1_c3_ar", {arvalid, rready}, 2'b10);
    step(); arready = 0;
    chk("r1_c4", {arvalid, rready}, 2'b01);
    step();
    step();
    step(); rvalid = 1;
    chk("r1_c7", {rready, resp_valid}, 2'b10);
    step(); rvalid = 0;
    chk("r1_c8_resp", {resp_valid, resp_err}, 2'b10);
    chk("r1_c8_data", resp_data, 32'h1234_5678);
    step();
    chk("r1_c9_hold", {resp_valid, resp_data}, {1'b0, 32'h1234_5678});

    // Skewed write: WREADY cycle 1, AWREADY cycle 4, SLVERR response, zero strobe
    req_valid = 1; req_wen = 1; req_addr = 32'h3000_000C; req_data = 32'hA5A5_5A5A; req_wmask = 4'h0;
    step(); req_valid = 0; wready = 1;
    chk("w2_c1", {awvalid, wvalid}, 2'b11);
    chk("w2_wstrb0", wstrb, 4'h0);
    step(); wready = 0;
    chk("w2_c2", {awvalid, wvalid, bready}, 3'b100);
    step();
    chk("w2_c3", {awvalid, wvalid, bready}, 3'b100);
    step(); awready = 1;
    chk("w2_c4", {awvalid, wvalid, bready, awaddr}, {3'b100, 32'h3000_000C});
    step(); awready = 0; bvalid = 1; bresp = 2'b10;
    chk("w2_c5", {awvalid, wvalid, bready}, 3'b001);
    step(); bvalid = 0; bresp = 0;
    chk("w2_c6_resp", {resp_valid, resp_err, resp_data}, {2'b11, 32'h0});
    step();
    chk("w2_c7_hold", {resp_valid, resp_err}, 2'b01);

    // DECERR read with a second request held during the first
    arready = 1;
    req_valid = 1; req_wen = 0; req_addr = 32'h4000_0000;
    step(); req_addr = 32'h4000_0004;
    chk("bp_c1", {arvalid, req_ready}, 2'b10);
    step(); rvalid = 1; rresp = 2'b11; rdata = 32'hCAFE_F00D;
    chk("bp_c2", {rready, req_ready}, 2'b10);
    step(); rvalid = 0; rresp = 0;
    chk("bp_c3_resp", {resp_valid, resp_err, req_ready}, 3'b110);
    chk("bp_c3_data", resp_data, 32'hCAFE_F00D);
    step();
    chk("bp_c4_accept", {req_ready, resp_valid}, 2'b10);
    step(); req_valid = 0;
    chk("bp_c5_ar", {arvalid, req_ready, araddr}, {2'b10, 32'h4000_0004});
    step(); rvalid = 1; rdata = 32'h0BAD_F00D;
    chk("bp_c6", rready, 1);
    step(); rvalid = 0;
    chk("bp_c7_resp", {resp_valid, resp_err, resp_data}, {2'b10, 32'h0BAD_F00D});
    step();

    // Reset while AWVALID is high
    arready = 0;
    req_valid = 1; req_wen = 1; req_addr = 32'h5000_0000; req_data = 32'h1111_1111; req_wmask = 4'h3;
    step(); req_valid = 0;
    chk("rw_c1", awvalid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rw_async_vld", {awvalid, wvalid, bready, arvalid, rready, resp_valid}, 0);
    chk("rw_async_ready", req_ready, 1);
    chk("rw_async_out", {awaddr, resp_err}, 0);
    chk("rw_async_wdata", {wdata, wstrb, resp_data}, 0);
    @(posedge clk); #1 reset = 1'b0;
    arready = 1;
    req_valid = 1; req_wen = 0; req_addr = 32'h6000_0010;
    step(); req_valid = 0; rdata = 32'h600D_600D;
    chk("rr_c1", {arvalid, awvalid, araddr}, {2'b10, 32'h6000_0010});
    step(); rvalid = 1;
    chk("rr_c2", rready, 1);
    step(); rvalid = 0;
    chk("rr_c3_resp", {resp_valid, resp_err, resp_data}, {2'b10, 32'h600D_600D});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
